// File: rtl/core_v2.sv
// core_v2: multi-cycle RV32I-subset core (FETCH/EXEC/MEM/WB/HALT).
// Instruction and data buses use req/ack handshakes with optional wait states.
module core_v2 #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    input  logic [ADDR_W-1:0] last_pc,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata,
    output logic              halted,
    output logic [31:0]       retired
);

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       res_q, res_d;
    logic [31:0]       retired_q, retired_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic [31:0]       rf_q [32];
    logic              rf_we;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic        is_lui, is_jal, is_br, is_lw, is_sw;
    logic        is_opi, is_op, is_ebreak, legal, has_rd;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign f3     = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign f7     = instr_q[31:25];

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                    instr_q[11:8], 1'b0};
    assign imm_j = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20],
                    instr_q[30:21], 1'b0};
    assign imm_u = {instr_q[31:12], 12'b0};

    assign is_lui    = opcode == 7'h37;
    assign is_jal    = opcode == 7'h6f;
    assign is_br     = opcode == 7'h63 && f3[2:1] == 2'b00;
    assign is_lw     = opcode == 7'h03 && f3 == 3'b010;
    assign is_sw     = opcode == 7'h23 && f3 == 3'b010;
    assign is_opi    = opcode == 7'h13 &&
                       (f3 == 3'b001 ? f7 == 7'h00 :
                        f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
    assign is_op     = opcode == 7'h33 &&
                       (f7 == 7'h00 ||
                        (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
    assign is_ebreak = instr_q == 32'h0010_0073;
    assign legal     = is_lui | is_jal | is_br | is_lw | is_sw |
                       is_opi | is_op | is_ebreak;
    assign has_rd    = is_lui | is_jal | is_lw | is_opi | is_op;

    logic [31:0] rs1v, rs2v, op_b, alu, ea, link;
    logic [4:0]  shamt;
    logic        alt, taken;
    logic [ADDR_W-1:0] pc_inc, j_off, b_off;

    assign rs1v  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2v  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign op_b  = is_op ? rs2v : imm_i;
    assign shamt = op_b[4:0];
    // bit 30 selects SUB/SRA only for OP, and for OP-IMM only on right shifts
    assign alt   = f7[5] && (is_op || f3 == 3'b101);
    assign taken = f3[0] ? (rs1v != rs2v) : (rs1v == rs2v);
    assign ea    = rs1v + (is_sw ? imm_s : imm_i);

    assign pc_inc = pc_q + ADDR_W'(1);
    assign link   = 32'(pc_inc) << 2;
    assign j_off  = ADDR_W'($signed(imm_j) >>> 2);
    assign b_off  = ADDR_W'($signed(imm_b) >>> 2);

    always_comb begin
        alu = '0;
        case (f3)
            3'b000:  alu = alt ? rs1v - op_b : rs1v + op_b;
            3'b001:  alu = rs1v << shamt;
            3'b010:  alu = {31'b0, $signed(rs1v) < $signed(op_b)};
            3'b011:  alu = {31'b0, rs1v < op_b};
            3'b100:  alu = rs1v ^ op_b;
            3'b101:  alu = alt ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'b110:  alu = rs1v | op_b;
            default: alu = rs1v & op_b;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        instr_d      = instr_q;
        res_d        = res_q;
        retired_d    = retired_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rf_we        = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (imem_req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (1'b1)
                    is_lui:  res_d = imm_u;
                    is_jal:  res_d = link;
                    default: res_d = alu;
                endcase
                npc_d = pc_inc;
                if (is_jal)
                    npc_d = pc_q + j_off;
                else if (is_br && taken)
                    npc_d = pc_q + b_off;
                if (is_lw || is_sw) begin
                    dmem_we_d    = is_sw;
                    dmem_addr_d  = ADDR_W'(ea >> 2);
                    dmem_wdata_d = rs2v;
                end
                unique case (1'b1)
                    !legal || is_ebreak: state_d = HALT;
                    is_lw || is_sw:      state_d = MEM;
                    default:             state_d = WB;
                endcase
            end
            MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    if (!dmem_we_q)
                        res_d = dmem_rdata;
                    state_d = WB;
                end
            end
            WB: begin
                rf_we     = has_rd && rd != 5'd0;
                pc_d      = npc_q;
                retired_d = retired_q + 32'd1;
                state_d   = (pc_q == last_pc) ? HALT : FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // requests are registered so they track the state being entered
    assign imem_req_d = state_d == FETCH;
    assign dmem_req_d = state_d == MEM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            npc_q        <= RESET_PC;
            instr_q      <= '0;
            res_q        <= '0;
            retired_q    <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            instr_q      <= instr_d;
            res_q        <= res_d;
            retired_q    <= retired_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    // register file has no reset
    always_ff @(posedge clk) begin
        if (rf_we)
            rf_q[rd] <= res_q;
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dbg_rdata  = (dbg_raddr == 5'd0) ? 32'd0 : rf_q[dbg_raddr];
    assign halted     = state_q == HALT;
    assign retired    = retired_q;

endmodule
